sram_slave_write: RTL

SRAM_SLAVE_WRITE -- requirements
Module: sram_slave_write

---
 rtl/sram_slave_write.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sram_slave_write.sv
// sram_slave_write: AXI4 write-channel slave that turns INCR bursts into single-port SRAM writes.
// Ports:
//   ACLK, ARESETn       clock and asynchronous active-high reset
//   AW*/W*/B*           AXI write address, data and response channels
//   rd_busy_i           read side currently owns the SRAM port (blocks AW acceptance only)
//   wr_busy_o           write side owns, or is claiming this cycle, the SRAM port
//   CEB, WEB, BWEB      active-low SRAM chip, write and bit-write enables
//   A, DI               SRAM word address and write data
module sram_slave_write #(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [LEN_W-1:0]    AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic                rd_busy_i,
    output logic                wr_busy_o,
    output logic                CEB,
    output logic                WEB,
    output logic [DATA_W-1:0]   BWEB,
    output logic [SRAM_AW-1:0]  A,
    output logic [DATA_W-1:0]   DI
);
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_t;
    state_t               state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [SRAM_AW-1:0]   base_q, base_d, a_q, a_d;
    logic [LEN_W-1:0]     len_q, len_d, cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    di_q, di_d;
    logic                 aw_hs, w_hs, wr_en;
    logic                 unused_addr;
    assign unused_addr = &{1'b0, AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0]};
    // AWREADY is gated by the reset level so it reads 0 for the whole reset pulse.
    always_comb begin
        AWREADY   = (state_q == ST_IDLE) && !rd_busy_i && !ARESETn;
        WREADY    = state_q == ST_DATA;
        BVALID    = state_q == ST_RESP;
        aw_hs     = AWVALID && AWREADY;
        w_hs      = WVALID && WREADY;
        wr_en     = w_hs && !err_q;
        BID       = BVALID ? id_q : '0;
        BRESP     = (BVALID && err_q) ? 2'b10 : 2'b00;
        wr_busy_o = (state_q != ST_IDLE) || aw_hs;
        CEB       = !wr_en;
        WEB       = !wr_en;
        A         = wr_en ? base_q + SRAM_AW'(cnt_q) : a_q;
        DI        = wr_en ? WDATA : di_q;
        BWEB      = '1;
        for (int i = 0; i < DATA_W/8; i++)
            BWEB[i*8 +: 8] = (wr_en && WSTRB[i]) ? 8'h00 : 8'hFF;
    end
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        a_d     = A;
        di_d    = DI;
        case (state_q)
            ST_IDLE: if (aw_hs) begin
                id_d    = AWID;
                base_d  = AWADDR[SRAM_AW+1:2];
                len_d   = AWLEN;
                cnt_d   = '0;
                err_d   = (AWBURST != 2'b01) || (AWSIZE != 3'b010);
                state_d = ST_DATA;
            end
            ST_DATA: if (w_hs) begin
                cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
                // WLAST must coincide exactly with the beat numbered AWLEN; early or late is an error.
                err_d   = err_q || (WLAST != (cnt_q == len_q));
                state_d = WLAST ? ST_RESP : ST_DATA;
            end
            ST_RESP: if (BREADY) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            a_q     <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            a_q     <= a_d;
            di_q    <= di_d;
        end
    end
endmodule
